dht11_responder: RTL and testbench
==================================

# dht11_responder

Synthesizable DHT11 sensor emulator: the single-wire responder that answers a host start pulse with a 40-bit humidity/temperature frame plus checksum. It is the far end of the DHT11 link from the host-side driver and display path. It gives a loopback target for bring-up and simulation, and lets a board present known sensor values without a physical DHT11.

## Interface
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz. Must be a multiple of 1_000_000. `CPU = CLK_FREQ/1_000_000` cycles per µs.
- `START_MIN_US`, 18000: minimum host low time accepted as a start request.
- `RESP_WAIT_US`, 30: delay after host release before the acknowledge.
- `sys_clk  in  1`: the only clock. All logic is on its rising edge.
- `sys_rst  in  1`: reset, synchronous, active-high.
- `dq_in  in  1`: sampled single-wire level (pad input, asynchronous).
- `dq_oe  out  1`: 1 = pull the line low, 0 = release (pull-up high). Registered.
- `data_in  in  32`: frame payload. [31:24] humidity int, [23:16] humidity frac, [15:8] temp int, [7:0] temp frac with bit7 = sign.
- `busy  out  1`: high from start acceptance until the frame has ended.
- `frame_done  out  1`: one-cycle pulse when the end-low phase completes.

## Operation
- dq_in passes through a 2-flop synchronizer; falling and rising edges are detected on the synchronized level.
- States and transitions:
  - IDLE → HOST_LOW on a falling edge.
  - HOST_LOW counts cycles while the line is low. On a rising edge: count ≥ START_MIN_US*CPU → WAIT_REL; otherwise → IDLE (runt pulse ignored, no output).
  - WAIT_REL: RESP_WAIT_US → ACK_LOW (80 µs, dq_oe=1) → ACK_HIGH (80 µs, dq_oe=0) → BIT_LOW.
  - BIT_LOW (50 µs, dq_oe=1) → BIT_HIGH (dq_oe=0; 27 µs for a 0, 70 µs for a 1). Repeats for 40 bits, then → END_LOW (50 µs, dq_oe=1) → IDLE.
- Payload is latched into a 40-bit shift register on the HOST_LOW→WAIT_REL transition. The register holds data_in followed by the checksum = (sum of the four bytes) mod 256, with the carry discarded (8-bit wrap).
- Bits are sent MSB first: humidity int, humidity frac, temp int, temp frac, checksum. Changes on data_in after the latch do not affect the frame in flight.
- From WAIT_REL through END_LOW, dq_in is ignored; host contention is not detected.
- Reset: state IDLE, dq_oe=0, busy=0, frame_done=0, counters and shift register zero.

## Timing
- Every phase of N µs lasts exactly N*CPU sys_clk cycles, measured from the first cycle dq_oe takes the phase value.
- A single phase counter is cleared on each state entry. Its width is $clog2(START_MIN_US*CPU+1); it saturates in HOST_LOW if the host holds the line low indefinitely.
- Edge-detect latency: a dq_in transition is acted on 3 cycles after it occurs (2 sync flops + edge register).
- busy rises the cycle WAIT_REL is entered and falls the cycle after frame_done.
- frame_done pulses on the last cycle of END_LOW; dq_oe is 0 on the next cycle.
- Synchronous reset mid-frame: dq_oe=0 on the first edge where sys_rst is sampled high. No partial frame resumes afterwards.
- Back-to-back frames: a falling edge is only honoured in IDLE. A new start can begin on the cycle after the return to IDLE.

## Configuration
- `DHT11_RESP_ERR_INJ_EN` defined: adds input port `err_inj` (1 bit). When err_inj is sampled high at latch time, the transmitted checksum is XORed with 8'h01 for that frame.
- Macro undefined: no err_inj port, and the checksum is always correct.

## Structure
- Shared package `dht11_pkg`:
  - state enum;
  - µs constants (80 ack, 50 bit-low, 27 zero-high, 70 one-high, 50 end-low);
  - frame byte offsets;
  - checksum function.
- One sub-module, `dht11_dq_sync`: 2-flop synchronizer plus registered rise/fall pulses. The FSM, counter and shift register stay in the top module.

## Test plan
All tests use CLK_FREQ=2_000_000 and START_MIN_US=100.
- data_in=32'h3C00_1905, host low 120 µs then release → ACK 160/160 cycles, 40 bits 3C 00 19 05 5A decoded from high widths (54 / 140 cycles), frame_done once, busy then low.
- data_in=32'h2800_0385 (negative temp) → checksum byte B0, temp frac byte 85 sent unchanged.
- Host low 50 µs (runt) → dq_oe stays 0, busy stays 0, FSM back in IDLE.
- data_in changed to 32'hFFFF_FFFF during bit 10 → remaining bits and checksum still from the latched 3C00_1905 frame.
- sys_rst asserted during ACK_HIGH and during bit 20 → dq_oe=0 next edge. A following valid start produces a complete correct frame.
- With DHT11_RESP_ERR_INJ_EN defined and err_inj=1 at latch on 3C00_1905 → checksum byte 5B; with err_inj=0 → 5A.

Source files
------------

// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
// dht11_pkg: shared definitions for the DHT11 responder.
// FSM state encoding, phase lengths in microseconds, payload byte layout
// and the frame checksum helper.
package dht11_pkg;

    // Responder FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST_LOW,
        S_WAIT_REL,
        S_ACK_LOW,
        S_ACK_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } dht11_state_e;

    // Phase lengths in microseconds
    localparam int unsigned US_ACK       = 80;
    localparam int unsigned US_BIT_LOW   = 50;
    localparam int unsigned US_ZERO_HIGH = 27;
    localparam int unsigned US_ONE_HIGH  = 70;
    localparam int unsigned US_END_LOW   = 50;

    // Frame layout: 32-bit payload followed by an 8-bit checksum
    localparam int FRAME_BITS    = 40;
    localparam int HUM_INT_LSB   = 24;
    localparam int HUM_FRAC_LSB  = 16;
    localparam int TEMP_INT_LSB  = 8;
    localparam int TEMP_FRAC_LSB = 0;

    // Checksum is the 8-bit wrapping sum of the four payload bytes
    function automatic logic [7:0] dht11_checksum(input logic [31:0] payload);
        logic [7:0] sum;
        sum = payload[HUM_INT_LSB +: 8] + payload[HUM_FRAC_LSB +: 8]
            + payload[TEMP_INT_LSB +: 8] + payload[TEMP_FRAC_LSB +: 8];
        return sum;
    endfunction

endpackage

// File: rtl/dht11_dq_sync.sv
`timescale 1ns/1ps
// dht11_dq_sync: two-flop synchronizer for the asynchronous single-wire
// input, followed by registered one-cycle rise/fall pulses.
// Flops reset to 1 so an idle (pulled-up) line never looks like a fall.
module dht11_dq_sync (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_dq,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_rise;
    logic r_fall;

    // Synchronize the pad level and register edge pulses from the clean level
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_meta   <= i_dq;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_rise   <= r_sync & ~r_sync_d;
            r_fall   <= ~r_sync & r_sync_d;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
// dht11_responder: DHT11 sensor emulator. Waits for a long host low pulse,
// then answers with an 80/80 us acknowledge and a 40-bit frame (payload +
// checksum, MSB first), then a 50 us end-low.
// Optional feature macro: DHT11_RESP_ERR_INJ_EN adds input err_inj, which
// flips checksum bit 0 for the frame latched while it is high.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned RESP_WAIT_US = 30
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        frame_done
`ifdef DHT11_RESP_ERR_INJ_EN
    ,
    input  logic        err_inj
`endif
);

    localparam int unsigned CPU       = CLK_FREQ / 1_000_000;
    localparam int unsigned START_CYC = START_MIN_US * CPU;
    localparam int          CNT_W     = $clog2(START_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Terminal counts: a phase of N us ends when the counter reads N*CPU-1
    localparam cnt_t CNT_MAX    = '1;
    localparam cnt_t START_THR  = cnt_t'(START_CYC);
    localparam cnt_t WAIT_LAST  = cnt_t'(RESP_WAIT_US * CPU - 1);
    localparam cnt_t ACK_LAST   = cnt_t'(US_ACK * CPU - 1);
    localparam cnt_t BLOW_LAST  = cnt_t'(US_BIT_LOW * CPU - 1);
    localparam cnt_t ZERO_LAST  = cnt_t'(US_ZERO_HIGH * CPU - 1);
    localparam cnt_t ONE_LAST   = cnt_t'(US_ONE_HIGH * CPU - 1);
    localparam cnt_t END_LAST   = cnt_t'(US_END_LOW * CPU - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

    dht11_state_e            r_state;
    dht11_state_e            w_state_next;
    cnt_t                    r_cnt;
    logic [5:0]              r_bit_idx;
    logic [FRAME_BITS-1:0]   r_shift;
    logic                    r_dq_oe;
    logic                    r_busy;
    logic                    w_rise;
    logic                    w_fall;
    logic [7:0]              w_csum;
    cnt_t                    w_high_last;
    logic                    w_state_change;

    dht11_dq_sync u_sync (
        .i_clk  (sys_clk),
        .i_srst (sys_rst),
        .i_dq   (dq_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

`ifdef DHT11_RESP_ERR_INJ_EN
    assign w_csum = dht11_checksum(data_in) ^ {7'd0, err_inj};
`else
    assign w_csum = dht11_checksum(data_in);
`endif

    // High time of the current data bit depends on the bit being sent
    assign w_high_last    = r_shift[FRAME_BITS-1] ? ONE_LAST : ZERO_LAST;
    assign w_state_change = (w_state_next != r_state);

    // Next-state logic; host edges only matter in IDLE and HOST_LOW
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_next = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (w_rise) w_state_next = (r_cnt >= START_THR) ? S_WAIT_REL : S_IDLE;
            end
            S_WAIT_REL: begin
                if (r_cnt == WAIT_LAST) w_state_next = S_ACK_LOW;
            end
            S_ACK_LOW: begin
                if (r_cnt == ACK_LAST) w_state_next = S_ACK_HIGH;
            end
            S_ACK_HIGH: begin
                if (r_cnt == ACK_LAST) w_state_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (r_cnt == BLOW_LAST) w_state_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (r_cnt == w_high_last)
                    w_state_next = (r_bit_idx == LAST_BIT) ? S_END_LOW : S_BIT_LOW;
            end
            S_END_LOW: begin
                if (r_cnt == END_LAST) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so they
    // line up exactly with the phase the state register holds
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_dq_oe <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_dq_oe <= (w_state_next == S_ACK_LOW) || (w_state_next == S_BIT_LOW)
                    || (w_state_next == S_END_LOW);
            r_busy  <= (w_state_next != S_IDLE) && (w_state_next != S_HOST_LOW);
        end
    end

    // Phase counter (cleared on state entry, saturating) and frame shifter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_state_change) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + cnt_t'(1);
            end

            if (r_state == S_HOST_LOW && w_state_next == S_WAIT_REL) begin
                r_shift   <= {data_in, w_csum};
                r_bit_idx <= '0;
            end else if (r_state == S_BIT_HIGH && w_state_change) begin
                r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                r_bit_idx <= r_bit_idx + 6'd1;
            end
        end
    end

    assign dq_oe      = r_dq_oe;
    assign busy       = r_busy;
    assign frame_done = (r_state == S_END_LOW) && (r_cnt == END_LAST);

endmodule

// File: tb/tb_dht11_responder.sv
`timescale 1ns/1ps
// tb_dht11_responder: directed test of the DHT11 responder at 2 MHz with a
// 100 us start threshold. A phase-list model built from the frame bytes is
// compared cycle by cycle against dq_oe/busy/frame_done; a pulse-width
// decoder recovers the transmitted bytes for literal comparison.
module tb_dht11_responder;

    localparam int CPU    = 2;
    localparam int WAIT_C = 30 * CPU;
    localparam int ACK_C  = 80 * CPU;
    localparam int BL_C   = 50 * CPU;
    localparam int ZH_C   = 27 * CPU;
    localparam int OH_C   = 70 * CPU;
    localparam int END_C  = 50 * CPU;
    localparam int HOST_C = 120 * CPU;
    localparam int RUNT_C = 50 * CPU;

    logic        sys_clk  = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        host_low = 1'b0;
    logic [31:0] data_in  = 32'h0;
`ifdef DHT11_RESP_ERR_INJ_EN
    logic        err_inj  = 1'b0;
`endif
    logic        dq_in;
    logic        dq_oe;
    logic        busy;
    logic        frame_done;

    // Open-drain line: low if either side pulls
    assign dq_in = ~(host_low | dq_oe);

    dht11_responder #(
        .CLK_FREQ     (2_000_000),
        .START_MIN_US (100),
        .RESP_WAIT_US (30)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .dq_in      (dq_in),
        .dq_oe      (dq_oe),
        .data_in    (data_in),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef DHT11_RESP_ERR_INJ_EN
        ,
        .err_inj    (err_inj)
`endif
    );

    always #250 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- model ----------------
    logic [39:0] exp_frame = '0;
    int          ph_len[$];
    bit          ph_oe[$];
    bit          armed   = 1'b0;
    int          rel_cyc = 0;

    function automatic logic [7:0] model_csum(input logic [31:0] d, input bit err);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'((d >> (8 * i)) & 32'hFF);
        s = s % 256;
        if (err) s = s ^ 1;
        return 8'(s);
    endfunction

    task automatic model_build(input logic [31:0] d, input bit err);
        exp_frame = {d, model_csum(d, err)};
        ph_len.delete();
        ph_oe.delete();
        ph_len.push_back(WAIT_C); ph_oe.push_back(1'b0);
        ph_len.push_back(ACK_C);  ph_oe.push_back(1'b1);
        ph_len.push_back(ACK_C);  ph_oe.push_back(1'b0);
        for (int i = 39; i >= 0; i--) begin
            ph_len.push_back(BL_C); ph_oe.push_back(1'b1);
            ph_len.push_back(exp_frame[i] ? OH_C : ZH_C); ph_oe.push_back(1'b0);
        end
        ph_len.push_back(END_C); ph_oe.push_back(1'b1);
    endtask

    // Cycle offset (from busy rise) of the start of data bit n
    function automatic int bit_start(input int n);
        int s;
        s = WAIT_C + 2 * ACK_C;
        for (int i = 0; i < n; i++) s += BL_C + (exp_frame[39 - i] ? OH_C : ZH_C);
        return s;
    endfunction

    // ---------------- compare process ----------------
    task automatic run_frame();
        int total;
        int k;
        int lat;
        bit bad;
        logic [2:0] got;
        logic [2:0] want;
        total = 0;
        k = 0;
        lat = cyc - rel_cyc;
        check($sformatf("start latency %0d cycles within 3..4", lat), (lat >= 3 && lat <= 4), 1);
        foreach (ph_len[i]) total += ph_len[i];
        for (int p = 0; p < ph_len.size(); p++) begin
            bad  = 1'b0;
            got  = '0;
            want = '0;
            for (int c = 0; c < ph_len[p]; c++) begin
                if (!armed) return;
                if (!bad) begin
                    want = {ph_oe[p], 1'b1, (k == total - 1)};
                    got  = {dq_oe, busy, frame_done};
                    if (got !== want) bad = 1'b1;
                end
                k++;
                @(negedge sys_clk);
            end
            check($sformatf("phase %0d {oe,busy,done}", p), got, want);
        end
        if (!armed) return;
        check("post-frame {oe,busy,done}", {dq_oe, busy, frame_done}, 3'b000);
        armed = 1'b0;
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge sys_clk);
            if (armed && busy) run_frame();
        end
    end

    // ---------------- pulse-width decoder ----------------
    logic [39:0] dec_bits = '0;
    int          dec_n    = 0;
    int          dec_bad  = 0;

    initial begin : decoder
        bit prev_oe;
        bit in_bits;
        int run;
        prev_oe = 1'b0;
        in_bits = 1'b0;
        run = 0;
        forever begin
            @(negedge sys_clk);
            if (dq_oe && !prev_oe) begin
                if (run == ACK_C) begin
                    in_bits = 1'b1;
                    dec_n   = 0;
                    dec_bad = 0;
                end else if (in_bits) begin
                    if (run == ZH_C || run == OH_C) begin
                        dec_bits = {dec_bits[38:0], (run == OH_C)};
                        dec_n++;
                    end else begin
                        dec_bad++;
                    end
                    if (dec_n == 40) in_bits = 1'b0;
                end
                run = 0;
            end else if (!dq_oe) begin
                run++;
            end
            prev_oe = dq_oe;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input logic [31:0] d, input bit err);
        repeat (20) @(negedge sys_clk);
        data_in = d;
`ifdef DHT11_RESP_ERR_INJ_EN
        err_inj = err;
`endif
        model_build(d, err);
        host_low = 1'b1;
        repeat (HOST_C) @(negedge sys_clk);
        host_low = 1'b0;
        rel_cyc  = cyc;
        armed    = 1'b1;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, " busy rose"}, busy, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (armed && n < 12000) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, " frame completed in budget"}, armed, 0);
        armed = 1'b0;
    endtask

    task automatic check_decode(input string name, input logic [39:0] lit);
        check({name, " decoded bit count"}, dec_n, 40);
        check({name, " bad pulse widths"}, dec_bad, 0);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s byte %0d", name, i), dec_bits[39 - 8 * i -: 8], lit[39 - 8 * i -: 8]);
    endtask

    task automatic reset_mid(input string name);
        bit seen;
        armed   = 1'b0;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check({name, " dq_oe after reset edge"}, dq_oe, 0);
        check({name, " busy after reset edge"}, busy, 0);
        check({name, " frame_done after reset edge"}, frame_done, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        seen = 1'b0;
        repeat (400) begin
            @(negedge sys_clk);
            if (dq_oe || busy || frame_done) seen = 1'b1;
        end
        check({name, " no activity resumes"}, seen, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        logic [39:0] lit;
        bit          seen;

        repeat (5) @(negedge sys_clk);
        check("reset dq_oe", dq_oe, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("idle dq_oe after reset", dq_oe, 0);

        // Pin the model against hand-computed checksums
        check("model csum 3C001905", model_csum(32'h3C00_1905, 1'b0), 8'h5A);
        check("model csum 28000385", model_csum(32'h2800_0385, 1'b0), 8'hB0);
        check("model csum FFFFFFFF", model_csum(32'hFFFF_FFFF, 1'b0), 8'hFC);
        check("model csum 3C001905 err", model_csum(32'h3C00_1905, 1'b1), 8'h5B);

        // Basic frame
        start_frame(32'h3C00_1905, 1'b0);
        wait_idle("frame1");
        lit = 40'h3C_00_19_05_5A;
        check_decode("frame1", lit);

        // Negative temperature: sign bit passes through unchanged
        start_frame(32'h2800_0385, 1'b0);
        wait_idle("frame2");
        lit = 40'h28_00_03_85_B0;
        check_decode("frame2", lit);

        // Runt start pulse is ignored
        repeat (20) @(negedge sys_clk);
        host_low = 1'b1;
        repeat (RUNT_C) @(negedge sys_clk);
        host_low = 1'b0;
        seen = 1'b0;
        repeat (300) begin
            @(negedge sys_clk);
            if (dq_oe || busy || frame_done) seen = 1'b1;
        end
        check("runt pulse produces no output", seen, 0);

        // Payload change mid-frame does not affect the latched frame
        start_frame(32'h3C00_1905, 1'b0);
        wait_busy("frame3");
        repeat (bit_start(10) + 5) @(negedge sys_clk);
        data_in = 32'hFFFF_FFFF;
        wait_idle("frame3");
        lit = 40'h3C_00_19_05_5A;
        check_decode("frame3", lit);

        // Reset during ACK_HIGH, then a clean frame
        start_frame(32'h3C00_1905, 1'b0);
        wait_busy("ackrst");
        repeat (WAIT_C + ACK_C + 20) @(negedge sys_clk);
        reset_mid("reset in ACK_HIGH");
        start_frame(32'h3C00_1905, 1'b0);
        wait_idle("after ack reset");
        lit = 40'h3C_00_19_05_5A;
        check_decode("after ack reset", lit);

        // Reset during bit 20 while the responder pulls low, then a clean frame
        start_frame(32'h3C00_1905, 1'b0);
        wait_busy("bitrst");
        repeat (bit_start(20) + 30) @(negedge sys_clk);
        check("bit20 low phase dq_oe before reset", dq_oe, 1);
        reset_mid("reset in bit 20");
        start_frame(32'h2800_0385, 1'b0);
        wait_idle("after bit reset");
        lit = 40'h28_00_03_85_B0;
        check_decode("after bit reset", lit);

`ifdef DHT11_RESP_ERR_INJ_EN
        // Corrupted checksum when err_inj is high at latch time
        start_frame(32'h3C00_1905, 1'b1);
        wait_idle("errinj");
        lit = 40'h3C_00_19_05_5B;
        check_decode("errinj", lit);
        err_inj = 1'b0;
`endif

        repeat (10) @(negedge sys_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
